logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the two-input gate primitives. One WIDTH-bit bitwise logic unit with a runtime-selected operation (AND/OR/NOT/XOR/NAND/NOR/XNOR/PASS).
- Valid/ready handshakes on input and output. 2-stage pipeline at full throughput.
- Chain mode folds each operand into the previous result, giving a running accumulator.
- Sits between operand producers and consumers in datapath exercises. Also provides zero and parity status flags.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- ACC_INIT, 0, value loaded into the chain accumulator on reset or acc_clr (WIDTH bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts beat this cycle
- op  in  3  operation: 0 AND, 1 OR, 2 NOT a, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS a
- chain  in  1  1: use accumulator as b operand instead of port b
- acc_clr  in  1  load accumulator with ACC_INIT (no beat required)
- a  in  WIDTH  operand a
- b  in  WIDTH  operand b
- out_valid  out  1  result beat offered
- out_ready  in  1  consumer accepts result
- v  out  WIDTH  result
- zero  out  1  v == 0
- parity  out  1  XOR-reduction of v

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - s1_valid=0, out_valid=0, v=0, zero=1, parity=0, acc=ACC_INIT.
  - in_ready is 1 in the first cycle after reset.
- Stage 1 (S1) registers {op, chain, a, b} on input handshake (in_valid && in_ready).
- Stage 2 (S2) registers the computed v, zero and parity when S1 advances.
- Advance and ready rules:
  - s1_adv = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s1_adv. This is combinational from out_ready; no combinational path from in_valid.
- Latency: a beat accepted in cycle N appears with out_valid=1 in cycle N+2 when there is no backpressure. Throughput is 1 beat/cycle.
- Compute at S1->S2 transfer:
  - b_eff = chain ? acc : b.
  - Result is the selected op, bitwise, WIDTH bits, no carries.
  - NOT and PASS ignore b_eff.
- Accumulator:
  - acc <= computed result on every s1_adv, regardless of chain.
  - Ordering is strictly by acceptance, so back-to-back chained beats see the immediately preceding result (no hazard, no bubble).
- acc_clr:
  - acc <= ACC_INIT on the clock edge where it is sampled high.
  - If s1_adv occurs in the same cycle, acc_clr wins for the acc update. The beat in S1 still computes with the pre-clear acc, and its result is still output.
- Backpressure:
  - While out_valid && !out_ready, v/zero/parity hold stable and S2 does not change.
  - S1 holds once full. in_ready=0 when both stages are full.
- Output handshake: beat retires when out_valid && out_ready. If S1 advances in the same cycle, the new result replaces it with no bubble.
- Beats are never dropped, duplicated or reordered.
- Reset mid-operation: all in-flight beats are discarded and acc returns to ACC_INIT. Nothing is emitted after rst is released until new beats are accepted.
- in_valid and out_ready may be asserted during rst. Both are ignored; in_ready=0 while rst=1.

Test Plan:
- Basic ops: WIDTH=8, out_ready=1, a=0xCA, b=0x5F, op=0..7 back to back.
  - Required v = 0x4A, 0xDF, 0x35, 0x95, 0xB5, 0x20, 0x6A, 0xCA on consecutive cycles, starting 2 cycles after the first accept.
  - Parity = 1, 1, 0, 0, 1, 1, 0, 0.
- Chain fold: ACC_INIT=0xFF, chain=1, op=AND, a=0xF0, 0x3C, 0x0F streamed.
  - Required v = 0xF0, 0x30, 0x00; the last result has zero=1.
- Backpressure: stream 5 beats with out_ready held 0 for 4 cycles.
  - in_ready drops after 2 beats are accepted; v stays stable.
  - After out_ready=1, all 5 results emerge in order, none lost.
- acc_clr collision: chain XOR beats a=0x01, 0x02; acc_clr pulsed in the cycle the second beat advances.
  - Required outputs 0x01 (wait—computed from ACC_INIT=0), then 0x03; acc becomes ACC_INIT afterwards.
  - A third chained beat with a=0x04 yields 0x04.
- Mid-stream reset: rst pulsed for 1 cycle with 2 beats in flight.
  - Next cycle out_valid=0, v=0, zero=1, and in_ready=1 after rst is released.
  - A chained OR of 0x00 afterwards outputs ACC_INIT.
- WIDTH=1 and WIDTH=32 builds: repeat the op sweep with random operands against a bitwise model.
  - Zero and parity must match the model on every beat.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with a chainable accumulator and zero/parity flags.
// Stage 1 holds the accepted operands; stage 2 holds the computed result.
module logic_unit_pipe #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             chain,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] v,
    output logic             zero,
    output logic             parity
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef struct packed {
        op_e              op;
        logic             chain;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    logic             s1_valid;
    s1_t              s1_q;
    logic [WIDTH-1:0] acc;
    logic             s1_adv;
    logic             in_fire;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res;

    // S1 drains whenever S2 is empty or retiring this cycle; in_ready never looks at in_valid.
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !rst && (!s1_valid || s1_adv);
    assign in_fire  = in_valid && in_ready;

    // Result of the beat sitting in S1, using the accumulator as of this cycle.
    always_comb begin
        b_eff = s1_q.chain ? acc : s1_q.b;
        res   = s1_q.a;
        unique case (s1_q.op)
            OP_AND:  res = s1_q.a & b_eff;
            OP_OR:   res = s1_q.a | b_eff;
            OP_NOT:  res = ~s1_q.a;
            OP_XOR:  res = s1_q.a ^ b_eff;
            OP_NAND: res = ~(s1_q.a & b_eff);
            OP_NOR:  res = ~(s1_q.a | b_eff);
            OP_XNOR: res = ~(s1_q.a ^ b_eff);
            OP_PASS: res = s1_q.a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            v         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            acc       <= ACC_INIT;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_q     <= '{op: op_e'(op), chain: chain, a: a, b: b};
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                out_valid <= 1'b1;
                v         <= res;
                zero      <= (res == '0);
                parity    <= ^res;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A clear in the same cycle as an advance wins the accumulator update.
            if (acc_clr) begin
                acc <= ACC_INIT;
            end else if (s1_adv) begin
                acc <= res;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: WIDTH=1, 8 and 32 instances share one stimulus stream
// and are checked against a 32-bit bitwise reference, sliced per width.
module tb_logic_unit_pipe;

    localparam logic [31:0] INIT32 = 32'h5A3C_C3FF;

    typedef struct {
        bit          clr;
        bit          has_exp;
        bit          lat_chk;
        logic [2:0]  op;
        bit          chain;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  exp8;
        int          acc_cyc;
    } item_t;

    logic        clk, rst;
    logic        in_valid, chain, acc_clr, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b;

    logic        in_ready1, ov1, zero1, parity1;
    logic [0:0]  v1;
    logic        in_ready8, ov8, zero8, parity8;
    logic [7:0]  v8;
    logic        in_ready32, ov32, zero32, parity32;
    logic [31:0] v32;

    item_t       q[$];
    logic [33:0] hold_q[$];
    int          pending;
    logic [31:0] m_acc;
    int          n_cmp, n_bad;
    int          cyc;
    bit          rand_ready;

    logic_unit_pipe #(.WIDTH(1), .ACC_INIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
        .chain(chain), .acc_clr(acc_clr), .a(a[0:0]), .b(b[0:0]), .out_valid(ov1),
        .out_ready(out_ready), .v(v1), .zero(zero1), .parity(parity1));

    logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'hFF)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .op(op),
        .chain(chain), .acc_clr(acc_clr), .a(a[7:0]), .b(b[7:0]), .out_valid(ov8),
        .out_ready(out_ready), .v(v8), .zero(zero8), .parity(parity8));

    logic_unit_pipe #(.WIDTH(32), .ACC_INIT(INIT32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .op(op),
        .chain(chain), .acc_clr(acc_clr), .a(a), .b(b), .out_valid(ov32),
        .out_ready(out_ready), .v(v32), .zero(zero32), .parity(parity32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~x;
            3'd3:    return x ^ y;
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            3'd6:    return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Monitor: pops one expected beat per output handshake and checks all three widths.
    initial begin
        item_t       it;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_q.delete();
            end else if (ov8 && out_ready) begin
                while (q.size() > 0 && q[0].clr) begin
                    it    = q.pop_front();
                    m_acc = INIT32;
                end
                if (q.size() == 0) begin
                    fail("unexpected_out");
                end else begin
                    it      = q.pop_front();
                    pending--;
                    r       = ref_op(it.op, it.a, it.chain ? m_acc : it.b);
                    m_acc   = r;
                    check("v32", v32, r);
                    check("zero32", zero32, r == 32'h0);
                    check("parity32", parity32, ^r);
                    check("v8", v8, r[7:0]);
                    check("zero8", zero8, r[7:0] == 8'h0);
                    check("parity8", parity8, ^r[7:0]);
                    check("v1", v1, r[0]);
                    check("zero1", zero1, !r[0]);
                    check("parity1", parity1, r[0]);
                    check("valid_1_32", {ov1, ov32}, 2'b11);
                    check("ready_1_32", {in_ready1, in_ready32}, {in_ready8, in_ready8});
                    if (it.has_exp) check("lit8", v8, it.exp8);
                    if (it.lat_chk) check("latency", cyc - it.acc_cyc, 2);
                    while (hold_q.size() > 0)
                        check("stall_hold", hold_q.pop_front(), {r == 32'h0, ^r, r});
                end
            end else if (ov8) begin
                hold_q.push_back({zero32, parity32, v32});
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [2:0] o, input bit ch, input logic [31:0] x,
                             input logic [31:0] y, input bit he, input logic [7:0] e,
                             input bit lc);
        item_t it;
        op       = o;
        chain    = ch;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready8) begin
                it = '{clr: 1'b0, has_exp: he, lat_chk: lc, op: o, chain: ch, a: x, b: y,
                       exp8: e, acc_cyc: cyc};
                q.push_back(it);
                pending++;
                break;
            end
            if (t > 200) begin
                fail("send_timeout");
                break;
            end
            @(posedge clk);
            #1;
        end
        cycle();
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && pending != 0; t++) cycle();
        if (pending != 0) fail("drain_timeout");
    endtask

    task automatic clr_pulse();
        item_t it;
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        it       = '{clr: 1'b1, has_exp: 1'b0, lat_chk: 1'b0, op: 3'd0, chain: 1'b0,
                     a: 32'h0, b: 32'h0, exp8: 8'h0, acc_cyc: 0};
        q.push_back(it);
        cycle();
        acc_clr = 1'b0;
    endtask

    // Holds rst for n cycles with in_valid/out_ready asserted, then checks the released state.
    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready8, 1'b0);
        q.delete();
        pending = 0;
        m_acc   = INIT32;
        @(posedge clk);
        #1;
        repeat (n - 1) cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", ov8, 1'b0);
        check("rst_v", v32, 32'h0);
        check("rst_zero", zero8, 1'b1);
        check("rst_parity", parity8, 1'b0);
        check("rst_rdy_after", in_ready8, 1'b1);
        cycle();
    endtask

    initial begin
        logic [7:0]  exp_basic[8];
        logic [7:0]  fold_a[3];
        logic [7:0]  fold_e[3];
        logic [31:0] ra, rb;

        exp_basic = '{8'h4A, 8'hDF, 8'h35, 8'h95, 8'hB5, 8'h20, 8'h6A, 8'hCA};
        fold_a    = '{8'hF0, 8'h3C, 8'h0F};
        fold_e    = '{8'hF0, 8'h30, 8'h00};
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; chain = 1'b0; acc_clr = 1'b0;
        a = 32'h0; b = 32'h0; out_ready = 1'b0; rand_ready = 1'b0;
        n_cmp = 0; n_bad = 0; pending = 0; m_acc = INIT32;

        do_reset(3);

        // Every op on fixed low bytes, back to back, with two-cycle latency.
        for (int i = 0; i < 8; i++) begin
            ra = ($urandom() & 32'hFFFF_FF00) | 32'h0000_00CA;
            rb = ($urandom() & 32'hFFFF_FF00) | 32'h0000_005F;
            send_beat(3'(i), 1'b0, ra, rb, 1'b1, exp_basic[i], 1'b1);
        end
        idle();
        drain();

        // Chained AND fold from ACC_INIT.
        clr_pulse();
        for (int i = 0; i < 3; i++)
            send_beat(3'd0, 1'b1, {$urandom_range(0, 65535), 8'h00, fold_a[i]}, $urandom(),
                      1'b1, fold_e[i], 1'b0);
        idle();
        drain();

        // Backpressure: two beats fill the pipe, then in_ready holds low.
        out_ready = 1'b0;
        send_beat(3'd3, 1'b0, $urandom(), $urandom(), 1'b0, 8'h0, 1'b0);
        send_beat(3'd1, 1'b0, $urandom(), $urandom(), 1'b0, 8'h0, 1'b0);
        ra = $urandom();
        rb = $urandom();
        op = 3'd6; a = ra; b = rb;
        repeat (2) begin
            @(negedge clk);
            check("bp_in_ready", in_ready8, 1'b0);
            check("bp_out_valid", ov8, 1'b1);
            cycle();
        end
        out_ready = 1'b1;
        send_beat(3'd6, 1'b0, ra, rb, 1'b0, 8'h0, 1'b0);
        send_beat(3'd4, 1'b0, $urandom(), $urandom(), 1'b0, 8'h0, 1'b0);
        send_beat(3'd0, 1'b1, $urandom(), $urandom(), 1'b0, 8'h0, 1'b0);
        idle();
        drain();

        // acc_clr collides with the second beat's advance.
        clr_pulse();
        send_beat(3'd3, 1'b1, 32'h1, $urandom(), 1'b1, 8'hFE, 1'b0);
        send_beat(3'd3, 1'b1, 32'h2, $urandom(), 1'b1, 8'hFC, 1'b0);
        clr_pulse();
        send_beat(3'd3, 1'b1, 32'h4, $urandom(), 1'b1, 8'hFB, 1'b0);
        idle();
        drain();

        // Reset with two beats in flight, then a chained OR of zero shows ACC_INIT.
        send_beat(3'd1, 1'b1, $urandom(), $urandom(), 1'b0, 8'h0, 1'b0);
        send_beat(3'd5, 1'b0, $urandom(), $urandom(), 1'b0, 8'h0, 1'b0);
        do_reset(1);
        send_beat(3'd1, 1'b1, 32'h0, $urandom(), 1'b1, 8'hFF, 1'b0);
        idle();
        drain();

        // Random ops, operands, gaps and backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) begin
                idle();
                drain();
                clr_pulse();
            end
            if ($urandom_range(0, 3) == 0) begin
                idle();
                cycle();
            end
            send_beat(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(),
                      $urandom(), 1'b0, 8'h0, 1'b0);
        end
        idle();
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
